// File: rtl/mram_spi_pkg.sv
// rtl/mram_spi_pkg.sv - shared widths, PTS state encoding and helpers for the MRAM SPI path
//
// Used by mram_read_pts, pts_bit_mux, SPI_Slave and the top level.
package mram_spi_pkg;

    localparam int MRAM_DATA_W = 16;
    localparam int MRAM_ADDR_W = 20;
    localparam int IDX_W       = 4;

    // MRAM tAA plus margin, in FPGA_clk cycles (legal range 0..15)
    localparam int PTS_ACCESS_CYCLES_DEF = 4;

    localparam int PTS_STATE_W = 2;
    localparam int PTS_CNT_W   = 4;

    localparam logic [PTS_STATE_W-1:0] PTS_IDLE    = 2'd0;
    localparam logic [PTS_STATE_W-1:0] PTS_WAIT    = 2'd1;
    localparam logic [PTS_STATE_W-1:0] PTS_CAPTURE = 2'd2;

    // Bit position inside the shadow word for a given serial index.
    // With a 16-bit word, 15-idx is the same as the bitwise inverse of idx.
    function automatic logic [IDX_W-1:0] pts_bit_pos(
        input logic [IDX_W-1:0] idx,
        input logic             msb_first
    );
        return msb_first ? ~idx : idx;
    endfunction

endpackage

// File: rtl/pts_bit_mux.sv
// rtl/pts_bit_mux.sv - registered 16:1 bit select for the MISO serial path
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   word        : shadow word to serialise
//   index       : serial bit index from the SPI slave
//   bit_out     : selected bit, registered (one cycle after word/index change)
module pts_bit_mux
    import mram_spi_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [MRAM_DATA_W-1:0] word,
    input  logic [IDX_W-1:0]       index,
    output logic                   bit_out
);

    logic bit_d;
    logic bit_q;

    always_comb begin
        bit_d = word[pts_bit_pos(index, MSB_FIRST)];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign bit_out = bit_q;

endmodule

// File: rtl/mram_read_pts.sv
// rtl/mram_read_pts.sv - MRAM read parallel-to-serial stage feeding the SPI slave MISO path
//
// Ports:
//   FPGA_clk, FPGA_rst_n : clock and asynchronous active-low reset
//   PTS_en               : read strobe from SPI slave, rising edge starts an access
//   chip_en_n, read_en_n : MRAM enables as driven to the device (active low)
//   data_in              : MRAM data bus, only trusted in the capture cycle
//   index                : serial bit select from SPI slave
//   clr_flags            : clears overrun and access_err
//   ser_data_out         : registered selected bit
//   busy, word_valid     : access in progress / shadow holds a fresh word
//   overrun, access_err  : sticky debug flags
//   capture_cnt          : wrapping count of successful captures
module mram_read_pts
    import mram_spi_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = PTS_ACCESS_CYCLES_DEF,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input  logic                   FPGA_clk,
    input  logic                   FPGA_rst_n,
    input  logic                   PTS_en,
    input  logic                   chip_en_n,
    input  logic                   read_en_n,
    input  logic [MRAM_DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]       index,
    input  logic                   clr_flags,
    output logic                   ser_data_out,
    output logic                   busy,
    output logic                   word_valid,
    output logic                   overrun,
    output logic                   access_err,
    output logic [7:0]             capture_cnt
);

    localparam logic [PTS_CNT_W-1:0] WAIT_LOAD = PTS_CNT_W'(ACCESS_CYCLES);

    logic [PTS_STATE_W-1:0] state_q, state_d;
    logic [PTS_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                   pts_en_q, pts_en_d;
    logic [MRAM_DATA_W-1:0] shadow_q, shadow_d;
    logic                   busy_q, busy_d;
    logic                   word_valid_q, word_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   access_err_q, access_err_d;
    logic [7:0]             capture_cnt_q, capture_cnt_d;

    logic start;
    logic mram_ok;
    logic overrun_set;
    logic access_err_set;

    always_comb begin
        start          = PTS_en & ~pts_en_q;
        mram_ok        = ~chip_en_n & ~read_en_n;
        overrun_set    = 1'b0;
        access_err_set = 1'b0;

        pts_en_d      = PTS_en;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        shadow_d      = shadow_q;
        busy_d        = busy_q;
        word_valid_d  = word_valid_q;
        capture_cnt_d = capture_cnt_q;

        case (state_q)
            PTS_IDLE: begin
                if (start) begin
                    state_d      = PTS_WAIT;
                    wait_cnt_d   = WAIT_LOAD;
                    busy_d       = 1'b1;
                    word_valid_d = 1'b0;
                end
            end

            PTS_WAIT: begin
                if (start) begin
                    overrun_set = 1'b1;
                    wait_cnt_d  = WAIT_LOAD;
                end else if (wait_cnt_q == '0) begin
                    state_d = PTS_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end

            PTS_CAPTURE: begin
                // data_in is only looked at when the device is actually driving it
                if (mram_ok) begin
                    shadow_d      = data_in;
                    word_valid_d  = 1'b1;
                    capture_cnt_d = capture_cnt_q + 8'd1;
                end else begin
                    access_err_set = 1'b1;
                end

                // A strobe landing on the capture cycle restarts the access; the
                // sample above is still kept, but the new strobe owns state/busy.
                if (start) begin
                    overrun_set  = 1'b1;
                    state_d      = PTS_WAIT;
                    wait_cnt_d   = WAIT_LOAD;
                    busy_d       = 1'b1;
                    word_valid_d = 1'b0;
                end else begin
                    state_d = PTS_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = PTS_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Set beats clear when both happen in the same cycle
        overrun_d    = overrun_set    | (overrun_q    & ~clr_flags);
        access_err_d = access_err_set | (access_err_q & ~clr_flags);
    end

    always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
        if (!FPGA_rst_n) begin
            state_q       <= PTS_IDLE;
            wait_cnt_q    <= '0;
            pts_en_q      <= 1'b0;
            shadow_q      <= '0;
            busy_q        <= 1'b0;
            word_valid_q  <= 1'b0;
            overrun_q     <= 1'b0;
            access_err_q  <= 1'b0;
            capture_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            pts_en_q      <= pts_en_d;
            shadow_q      <= shadow_d;
            busy_q        <= busy_d;
            word_valid_q  <= word_valid_d;
            overrun_q     <= overrun_d;
            access_err_q  <= access_err_d;
            capture_cnt_q <= capture_cnt_d;
        end
    end

    pts_bit_mux #(
        .MSB_FIRST (MSB_FIRST)
    ) u_bit_mux (
        .clk     (FPGA_clk),
        .rst_n   (FPGA_rst_n),
        .word    (shadow_q),
        .index   (index),
        .bit_out (ser_data_out)
    );

    assign busy        = busy_q;
    assign word_valid  = word_valid_q;
    assign overrun     = overrun_q;
    assign access_err  = access_err_q;
    assign capture_cnt = capture_cnt_q;

endmodule

// File: tb/tb_mram_read_pts.sv
// tb/tb_mram_read_pts.sv - directed self-checking bench for mram_read_pts
module tb_mram_read_pts;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pts_en;
    logic        cen_n;
    logic        ren_n;
    logic [15:0] data;
    logic [3:0]  index;
    logic        clr;

    logic       ser_a, busy_a, wv_a, ovr_a, err_a;
    logic [7:0] cnt_a;
    logic       ser_b, busy_b, wv_b, ovr_b, err_b;
    logic [7:0] cnt_b;

    int total = 0;
    int bad   = 0;

    // 16'hA5C3 read MSB first, and LSB first, by index 0..15
    bit exp_a5c3_msb [16] = '{1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1};
    bit exp_a5c3_lsb [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    always #5 clk = ~clk;

    mram_read_pts dut_a (
        .FPGA_clk     (clk),
        .FPGA_rst_n   (rst_n),
        .PTS_en       (pts_en),
        .chip_en_n    (cen_n),
        .read_en_n    (ren_n),
        .data_in      (data),
        .index        (index),
        .clr_flags    (clr),
        .ser_data_out (ser_a),
        .busy         (busy_a),
        .word_valid   (wv_a),
        .overrun      (ovr_a),
        .access_err   (err_a),
        .capture_cnt  (cnt_a)
    );

    mram_read_pts #(
        .ACCESS_CYCLES (0),
        .MSB_FIRST     (1'b0)
    ) dut_b (
        .FPGA_clk     (clk),
        .FPGA_rst_n   (rst_n),
        .PTS_en       (pts_en),
        .chip_en_n    (cen_n),
        .read_en_n    (ren_n),
        .data_in      (data),
        .index        (index),
        .clr_flags    (clr),
        .ser_data_out (ser_b),
        .busy         (busy_b),
        .word_valid   (wv_b),
        .overrun      (ovr_b),
        .access_err   (err_b),
        .capture_cnt  (cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        pts_en = 1'b0;
        cen_n  = 1'b1;
        ren_n  = 1'b1;
        data   = 16'h0000;
        index  = 4'd0;
        clr    = 1'b0;
        repeat (3) tick();
        chk("reset_a", {3'b0, ser_a, busy_a, wv_a, ovr_a, err_a, cnt_a}, 16'h0000);
        chk("reset_b", {3'b0, ser_b, busy_b, wv_b, ovr_b, err_b, cnt_b}, 16'h0000);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic capture of A5C3, busy window length for both instances
        data   = 16'hA5C3;
        cen_n  = 1'b0;
        ren_n  = 1'b0;
        pts_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("busy_win_a", {15'b0, busy_a}, 16'd1);
            chk("busy_win_b", {15'b0, busy_b}, (i < 2) ? 16'd1 : 16'd0);
        end
        tick();
        chk("busy_end_a", {15'b0, busy_a}, 16'd0);
        chk("wv_a", {15'b0, wv_a}, 16'd1);
        chk("cnt_a_1", {8'b0, cnt_a}, 16'd1);
        chk("wv_b", {15'b0, wv_b}, 16'd1);
        chk("cnt_b_1", {8'b0, cnt_b}, 16'd1);
        for (int i = 0; i < 16; i++) begin
            index = 4'(i);
            tick();
            chk("sweep_a5c3_a", {15'b0, ser_a}, {15'b0, exp_a5c3_msb[i]});
            chk("sweep_a5c3_b", {15'b0, ser_b}, {15'b0, exp_a5c3_lsb[i]});
        end
        index = 4'd1;
        #2;
        chk("latency_old", {15'b0, ser_a}, 16'd1);
        tick();
        chk("latency_new", {15'b0, ser_a}, 16'd0);
        pts_en = 1'b0;
        tick();

        // Capture 0001
        data   = 16'h0001;
        pts_en = 1'b1;
        repeat (8) tick();
        pts_en = 1'b0;
        chk("cnt_a_2", {8'b0, cnt_a}, 16'd2);
        chk("cnt_b_2", {8'b0, cnt_b}, 16'd2);
        for (int i = 0; i < 16; i++) begin
            index = 4'(i);
            tick();
            chk("sweep_0001_b", {15'b0, ser_b}, (i == 0) ? 16'd1 : 16'd0);
            chk("sweep_0001_a", {15'b0, ser_a}, (i == 15) ? 16'd1 : 16'd0);
        end

        // Recapture A5C3, then a failed access with read_en_n high
        data   = 16'hA5C3;
        pts_en = 1'b1;
        repeat (8) tick();
        pts_en = 1'b0;
        tick();
        chk("cnt_a_3", {8'b0, cnt_a}, 16'd3);
        data   = 16'hFFFF;
        ren_n  = 1'b1;
        pts_en = 1'b1;
        tick();
        chk("wv_clear_on_start", {15'b0, wv_a}, 16'd0);
        repeat (7) tick();
        chk("err_a", {15'b0, err_a}, 16'd1);
        chk("err_wv_a", {15'b0, wv_a}, 16'd0);
        chk("err_cnt_a", {8'b0, cnt_a}, 16'd3);
        chk("err_b", {15'b0, err_b}, 16'd1);
        chk("err_cnt_b", {8'b0, cnt_b}, 16'd3);
        for (int i = 0; i < 16; i++) begin
            index = 4'(i);
            tick();
            chk("shadow_kept_a", {15'b0, ser_a}, {15'b0, exp_a5c3_msb[i]});
        end
        chk("err_sticky_a", {15'b0, err_a}, 16'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("err_clr_a", {15'b0, err_a}, 16'd0);
        chk("err_clr_b", {15'b0, err_b}, 16'd0);
        pts_en = 1'b0;
        ren_n  = 1'b0;
        tick();

        // Second strobe 2 cycles into WAIT; clr_flags in the same cycle loses
        data   = 16'h5A5A;
        pts_en = 1'b1;
        tick();
        pts_en = 1'b0;
        tick();
        chk("ovr_before_a", {15'b0, ovr_a}, 16'd0);
        pts_en = 1'b1;
        clr    = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovr_set_a", {15'b0, ovr_a}, 16'd1);
        chk("ovr_set_b", {15'b0, ovr_b}, 16'd1);
        repeat (2) tick();
        chk("restart_busy_b", {15'b0, busy_b}, 16'd0);
        chk("restart_cnt_b", {8'b0, cnt_b}, 16'd5);
        repeat (3) tick();
        chk("restart_busy_a_e7", {15'b0, busy_a}, 16'd1);
        chk("restart_wv_a_e7", {15'b0, wv_a}, 16'd0);
        tick();
        chk("restart_busy_a_e8", {15'b0, busy_a}, 16'd0);
        chk("restart_wv_a_e8", {15'b0, wv_a}, 16'd1);
        chk("restart_cnt_a", {8'b0, cnt_a}, 16'd4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovr_clr_a", {15'b0, ovr_a}, 16'd0);
        chk("ovr_clr_b", {15'b0, ovr_b}, 16'd0);

        // Level held high for 50 cycles gives a single capture
        pts_en = 1'b0;
        tick();
        pts_en = 1'b1;
        repeat (50) tick();
        pts_en = 1'b0;
        tick();
        chk("level_cnt_a", {8'b0, cnt_a}, 16'd5);
        chk("level_cnt_b", {8'b0, cnt_b}, 16'd6);
        chk("level_ovr_a", {15'b0, ovr_a}, 16'd0);

        // Enough separate strobes to wrap dut_a's counter to 0
        for (int s = 0; s < 251; s++) begin
            pts_en = 1'b1;
            tick();
            pts_en = 1'b0;
            repeat (7) tick();
        end
        chk("wrap_cnt_a", {8'b0, cnt_a}, 16'd0);
        chk("wrap_cnt_b", {8'b0, cnt_b}, 16'd1);
        chk("wrap_ovr_a", {15'b0, ovr_a}, 16'd0);

        // Reset in the middle of an access
        data   = 16'h1234;
        pts_en = 1'b1;
        repeat (3) tick();
        chk("pre_reset_busy_a", {15'b0, busy_a}, 16'd1);
        rst_n  = 1'b0;
        pts_en = 1'b0;
        #1;
        chk("mid_reset_a", {3'b0, ser_a, busy_a, wv_a, ovr_a, err_a, cnt_a}, 16'h0000);
        chk("mid_reset_b", {3'b0, ser_b, busy_b, wv_b, ovr_b, err_b, cnt_b}, 16'h0000);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 16; i++) begin
            index = 4'(i);
            tick();
            chk("post_reset_ser_a", {15'b0, ser_a}, 16'd0);
            chk("post_reset_ser_b", {15'b0, ser_b}, 16'd0);
        end
        chk("post_reset_wv_a", {15'b0, wv_a}, 16'd0);
        chk("post_reset_wv_b", {15'b0, wv_b}, 16'd0);
        chk("post_reset_cnt_a", {8'b0, cnt_a}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mram_read_pts.md
Name: mram_read_pts

Overview:
- Parallel-to-serial stage that feeds the SPI slave's MISO path during MRAM reads.
- On each read strobe from the SPI slave it waits out the MRAM access time and samples the 16-bit MRAM data bus into a shadow register.
- It then presents the bit selected by the slave's 4-bit index on a registered serial output.
- It also reports busy, captured-word validity, overrun and access errors for debug LEDs/ILA.

Parameters:
- ACCESS_CYCLES, 4, FPGA_clk cycles from strobe detection to data sample (MRAM tAA plus margin, 0..15).
- MSB_FIRST, 1, 1: index 0 selects shadow[15]; 0: index 0 selects shadow[0].

Ports:
- FPGA_clk  in  1  system clock, all logic on its rising edge
- FPGA_rst_n  in  1  asynchronous active-low reset
- PTS_en  in  1  read strobe/level from SPI slave; rising edge starts an access
- chip_en_n  in  1  MRAM chip enable as driven to the device, active low
- read_en_n  in  1  MRAM output enable as driven to the device, active low
- data_in  in  16  MRAM data_line (may be Z/X outside read windows)
- index  in  4  bit select from SPI slave (cycle*8 + bitcnt)
- clr_flags  in  1  synchronous clear of overrun and access_err
- ser_data_out  out  1  selected bit, to SPI slave PTS_ser_data_in / MISO
- busy  out  1  high from strobe detection until capture completes
- word_valid  out  1  shadow holds a word captured since the last strobe
- overrun  out  1  sticky: new strobe edge arrived while busy
- access_err  out  1  sticky: chip_en_n or read_en_n high at sample cycle
- capture_cnt  out  8  wrapping count of successful captures

Behaviour:
- Reset (async assert, release synchronised by the top level): state IDLE, shadow=0, ser_data_out=0, busy=0, word_valid=0, overrun=0, access_err=0, capture_cnt=0, wait counter=0, PTS_en history flop=0.
- Edge detect: start = PTS_en & ~PTS_en_q, with PTS_en_q registered every cycle. A level held high produces one start only.
- States:
  - IDLE: on start, go to WAIT, load wait counter with ACCESS_CYCLES, set busy=1, clear word_valid.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to CAPTURE. With ACCESS_CYCLES=0, CAPTURE follows the start cycle immediately.
  - CAPTURE (one cycle): if chip_en_n==0 and read_en_n==0, then shadow<=data_in, word_valid<=1, capture_cnt<=capture_cnt+1 (wraps 255->0). Otherwise shadow is unchanged, word_valid stays 0 and access_err<=1. Next state is IDLE with busy<=0.
- start while in WAIT or CAPTURE:
  - overrun<=1.
  - Restart the access: counter reloaded, state WAIT.
  - In CAPTURE the sample for the current cycle is still taken; restart takes priority for state and busy.
- start in the same cycle that CAPTURE returns to IDLE is handled as a restart (the CAPTURE rule); no strobe is lost.
- Serial output:
  - ser_data_out <= shadow[MSB_FIRST ? 15-index : index], registered, one-cycle latency from an index or shadow change.
  - Updates every cycle regardless of state. During WAIT it shows the previous word; after reset it shows 0.
  - The SPI slave's 3-stage SCLK synchroniser gives at least 2 cycles of margin, so the latency is acceptable.
- clr_flags: clears overrun and access_err next cycle. If a set condition occurs in the same cycle, set wins.
- data_in is sampled only in CAPTURE. X/Z at other times must not propagate to any flop.
- Reset mid-access: everything returns to reset values immediately. No partial capture is visible after release.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package mram_spi_pkg:
  - state encoding localparams PTS_IDLE/PTS_WAIT/PTS_CAPTURE
  - MRAM_DATA_W=16, MRAM_ADDR_W=20, IDX_W=4
  - default ACCESS_CYCLES
  These widths are also used by SPI_Slave and the top level.
- One optional sub-module, pts_bit_mux: parameterised 16:1 bit select with MSB_FIRST plus output register. Everything else stays in the one module.

Test Plan:
- Reset then PTS_en 0->1, data_in=16'hA5C3, chip_en_n=read_en_n=0, ACCESS_CYCLES=4:
  - busy high for 6 cycles, word_valid=1, capture_cnt=1.
  - Sweep index 0..15 -> ser_data_out = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 (MSB_FIRST), each one cycle after index.
- Same with MSB_FIRST=0, data_in=16'h0001: index 0 -> 1, index 1..15 -> 0. With ACCESS_CYCLES=0, busy lasts 2 cycles.
- read_en_n=1 at capture, data_in=16'hFFFF:
  - access_err=1, word_valid=0, shadow keeps the previous 16'hA5C3, capture_cnt unchanged.
  - clr_flags pulse -> access_err=0.
- Second PTS_en edge 2 cycles into WAIT (PTS_en pulsed low then high): overrun=1, capture occurs ACCESS_CYCLES+1 cycles after the second edge, capture_cnt increments by 1 only.
- PTS_en held high for 50 cycles: exactly one capture. 256 separate strobes: capture_cnt wraps to 0.
- FPGA_rst_n low during WAIT with data_in=16'h1234: all outputs 0 immediately. After release with no strobe, ser_data_out=0 for every index and word_valid=0.
